// File: rtl/psl_pkg.sv
// rtl/psl_pkg.sv - shared PSL constants and read-engine state type
package psl_pkg;
  localparam int LINE_BYTES = 128;
  localparam int LINE_W = 1024;
  localparam int HALF_W = 512;
  localparam logic [12:0] CMD_READ_CL_NA = 13'h0A00;
  localparam logic [7:0] RSP_DONE = 8'h00;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FINISH} rd_state_t;
endpackage

// File: rtl/line_slot_buffer.sv
// rtl/line_slot_buffer.sv - per-tag cache-line store with busy/ready flags
module line_slot_buffer
  import psl_pkg::*;
#(
  parameter int NTAGS = 4,
  localparam int IDX_W = $clog2(NTAGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              issue_en,
  input  logic [IDX_W-1:0]  issue_idx,
  input  logic              free_en,
  input  logic [IDX_W-1:0]  free_idx,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_hi,
  input  logic [HALF_W-1:0] wr_data,
  input  logic              rsp_en,
  input  logic [IDX_W-1:0]  rsp_idx,
  input  logic              rsp_ok,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [LINE_W-1:0] rd_data,
  output logic [NTAGS-1:0]  busy,
  output logic [NTAGS-1:0]  ready
);
  logic [LINE_W-1:0] mem [NTAGS];
  logic [NTAGS-1:0]  busy_n;
  logic [NTAGS-1:0]  ready_n;

  // A failed response releases the slot so an aborting job can drain.
  always_comb begin
    busy_n  = busy;
    ready_n = ready;
    if (rsp_en) begin
      if (rsp_ok) ready_n[rsp_idx] = 1'b1;
      else        busy_n[rsp_idx]  = 1'b0;
    end
    if (free_en) begin
      busy_n[free_idx]  = 1'b0;
      ready_n[free_idx] = 1'b0;
    end
    if (issue_en) begin
      busy_n[issue_idx]  = 1'b1;
      ready_n[issue_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      busy  <= '0;
      ready <= '0;
    end else begin
      busy  <= busy_n;
      ready <= ready_n;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_hi) mem[wr_idx][HALF_W-1:0]      <= wr_data;
      else       mem[wr_idx][LINE_W-1:HALF_W] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/seq_read_engine.sv
// rtl/seq_read_engine.sv - splits a read job into line DMA reads, streams lines in order
module seq_read_engine
  import psl_pkg::*;
#(
  parameter int NTAGS   = 4,
  parameter int TAG_W   = 8,
  parameter int LINES_W = 16
) (
  input  logic              ha_pclock,
  input  logic              reset,
  input  logic              read_req,
  input  logic [63:0]       read_addr,
  input  logic [63:0]       read_size,
  output logic              read_ready,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [TAG_W-1:0]  cmd_tag,
  output logic [63:0]       cmd_ea,
  output logic [11:0]       cmd_size,
  input  logic              bw_valid,
  input  logic [TAG_W-1:0]  bw_tag,
  input  logic              bw_ad,
  input  logic [511:0]      bw_data,
  input  logic              rsp_valid,
  input  logic [TAG_W-1:0]  rsp_tag,
  input  logic [7:0]        rsp_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1023:0]     out_data,
  output logic [7:0]        out_bytes,
  output logic              out_last,
  output logic              rd_done,
  output logic              rd_error
);
  localparam int IDX_W = $clog2(NTAGS);
  localparam int CW    = LINES_W + 1;

  rd_state_t         state;
  logic [63:0]       base;
  logic [CW-1:0]     total_lines;
  logic [CW-1:0]     issued;
  logic [CW-1:0]     delivered;
  logic [6:0]        rem;

  logic [CW-1:0]     in_flight;
  logic [CW-1:0]     req_lines;
  logic              accept;
  logic              misaligned;
  logic              too_big;
  logic [IDX_W-1:0]  iss_idx;
  logic [IDX_W-1:0]  del_idx;
  logic [NTAGS-1:0]  busy;
  logic [NTAGS-1:0]  ready;
  logic              bw_hit;
  logic              rsp_hit;
  logic              rsp_fail;
  logic              proto_err;
  logic              active;
  logic              cmd_fire;
  logic              out_fire;
  logic              is_last;
  logic [1023:0]     slot_data;

  assign accept     = read_req && read_ready;
  assign misaligned = |read_addr[6:0];
  assign too_big    = read_size > (64'(LINE_BYTES) << LINES_W);
  assign req_lines  = read_size[LINES_W+7:7] + {{(CW-1){1'b0}}, |read_size[6:0]};

  assign active    = (state == S_ACTIVE);
  assign in_flight = issued - delivered;
  assign iss_idx   = issued[IDX_W-1:0];
  assign del_idx   = delivered[IDX_W-1:0];

  // Tags outside the slot range or on idle slots are protocol errors.
  assign bw_hit    = bw_valid && (bw_tag < TAG_W'(NTAGS)) && busy[bw_tag[IDX_W-1:0]];
  assign rsp_hit   = rsp_valid && (rsp_tag < TAG_W'(NTAGS)) && busy[rsp_tag[IDX_W-1:0]];
  assign rsp_fail  = rsp_hit && (rsp_code != RSP_DONE);
  assign proto_err = (bw_valid && !bw_hit) || (rsp_valid && !rsp_hit);

  assign cmd_valid = active && (issued < total_lines) && (in_flight < CW'(NTAGS)) && !rd_error;
  assign cmd_tag   = TAG_W'(iss_idx);
  assign cmd_ea    = base + {{(64-CW-7){1'b0}}, issued, 7'b0};
  assign cmd_size  = 12'(LINE_BYTES);
  assign cmd_fire  = cmd_valid && cmd_ready;

  assign out_valid = active && ready[del_idx] && !rd_error;
  assign is_last   = active && (delivered == total_lines - 1'b1);
  assign out_last  = is_last;
  assign out_bytes = (is_last && rem != 7'd0) ? {1'b0, rem} : 8'(LINE_BYTES);
  assign out_data  = slot_data;
  assign out_fire  = out_valid && out_ready;

  line_slot_buffer #(.NTAGS(NTAGS)) u_slots (
    .clk       (ha_pclock),
    .reset     (reset),
    .clear     (accept),
    .issue_en  (cmd_fire),
    .issue_idx (iss_idx),
    .free_en   (out_fire),
    .free_idx  (del_idx),
    .wr_en     (bw_hit && active),
    .wr_idx    (bw_tag[IDX_W-1:0]),
    .wr_hi     (bw_ad),
    .wr_data   (bw_data),
    .rsp_en    (rsp_hit && active),
    .rsp_idx   (rsp_tag[IDX_W-1:0]),
    .rsp_ok    (rsp_code == RSP_DONE),
    .rd_idx    (del_idx),
    .rd_data   (slot_data),
    .busy      (busy),
    .ready     (ready)
  );

  always_ff @(posedge ha_pclock) begin
    if (reset) begin
      state       <= S_IDLE;
      read_ready  <= 1'b1;
      rd_done     <= 1'b0;
      rd_error    <= 1'b0;
      base        <= '0;
      total_lines <= '0;
      issued      <= '0;
      delivered   <= '0;
      rem         <= '0;
    end else begin
      rd_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            read_ready  <= 1'b0;
            base        <= read_addr;
            total_lines <= req_lines;
            rem         <= read_size[6:0];
            issued      <= '0;
            delivered   <= '0;
            if (misaligned || too_big) begin
              rd_error <= 1'b1;
              state    <= S_FINISH;
            end else if (read_size == 64'd0) begin
              rd_error <= 1'b0;
              state    <= S_FINISH;
            end else begin
              rd_error <= 1'b0;
              state    <= S_ACTIVE;
            end
          end else if (rd_done) begin
            read_ready <= 1'b1;
          end
        end
        S_ACTIVE: begin
          if (cmd_fire) issued <= issued + 1'b1;
          if (out_fire) delivered <= delivered + 1'b1;
          if (rsp_fail || proto_err) rd_error <= 1'b1;
          // On error, wait only for slots still owed a response.
          if ((delivered == total_lines) || (rd_error && ((busy & ~ready) == '0)))
            state <= S_FINISH;
        end
        S_FINISH: begin
          rd_done <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_read_engine.sv
// tb/tb_seq_read_engine.sv - directed and randomized jobs against a line-level reference
module tb_seq_read_engine;
  localparam int NTAGS = 4;
  localparam int TAG_W = 8;
  localparam int LINES_W = 16;

  logic          ha_pclock, reset;
  logic          read_req, read_ready;
  logic [63:0]   read_addr, read_size;
  logic          cmd_valid, cmd_ready;
  logic [7:0]    cmd_tag;
  logic [63:0]   cmd_ea;
  logic [11:0]   cmd_size;
  logic          bw_valid, bw_ad;
  logic [7:0]    bw_tag;
  logic [511:0]  bw_data;
  logic          rsp_valid;
  logic [7:0]    rsp_tag, rsp_code;
  logic          out_valid, out_ready, out_last;
  logic [1023:0] out_data;
  logic [7:0]    out_bytes;
  logic          rd_done, rd_error;

  seq_read_engine #(.NTAGS(NTAGS), .TAG_W(TAG_W), .LINES_W(LINES_W)) dut (
    .ha_pclock(ha_pclock), .reset(reset),
    .read_req(read_req), .read_addr(read_addr), .read_size(read_size), .read_ready(read_ready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tag(cmd_tag), .cmd_ea(cmd_ea), .cmd_size(cmd_size),
    .bw_valid(bw_valid), .bw_tag(bw_tag), .bw_ad(bw_ad), .bw_data(bw_data),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_code(rsp_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_bytes(out_bytes),
    .out_last(out_last), .rd_done(rd_done), .rd_error(rd_error)
  );

  initial ha_pclock = 1'b0;
  always #5 ha_pclock = ~ha_pclock;

  typedef struct { logic [7:0] tag; logic [63:0] ea; } cmd_t;
  typedef struct { logic [1023:0] data; logic [7:0] bytes; logic last; } out_t;

  cmd_t          cmd_q[$];
  int            pend_q[$];
  out_t          out_q[$];
  logic [1023:0] line_data [0:63];
  int            vectors = 0;
  int            miscompares = 0;
  int            done_cnt;
  logic          done_err;

  always @(negedge ha_pclock) begin
    if (!reset) begin
      if (cmd_valid && cmd_ready) begin
        cmd_q.push_back('{cmd_tag, cmd_ea});
        pend_q.push_back(cmd_q.size() - 1);
      end
      if (out_valid && out_ready) out_q.push_back('{out_data, out_bytes, out_last});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ha_pclock);
    #1;
    if (rd_done) begin
      done_cnt++;
      done_err = rd_error;
      chk("ready_low_during_done", read_ready, 0);
    end
  endtask

  task automatic respond(input int pi, input logic [63:0] base, input int err_line, output logic failed);
    cmd_t c;
    logic [63:0] off;
    int idx;
    c = cmd_q[pend_q[pi]];
    pend_q.delete(pi);
    off = c.ea - base;
    idx = int'(off[12:7]);
    for (int w = 0; w < 32; w++) line_data[idx][32*w +: 32] = $urandom;
    failed = (idx == err_line);
    bw_valid = 1; bw_tag = c.tag; bw_ad = 0; bw_data = line_data[idx][1023:512];
    tick();
    bw_ad = 1; bw_data = line_data[idx][511:0];
    rsp_valid = 1; rsp_tag = c.tag; rsp_code = failed ? 8'h01 : 8'h00;
    tick();
    bw_valid = 0; rsp_valid = 0; rsp_code = 0;
  endtask

  // mode: 0 random response order, 1 in order, 2 newest first then oldest
  task automatic run_job(input logic [63:0] addr, input logic [63:0] size, input int mode,
                         input int err_line, input int stall, input int p_out);
    logic exp_err, err_sent, failed, stall_done;
    int nl, cyc, lat, nrsp, pi, cmd_at_err, out_at_err;
    exp_err = (addr[6:0] != 0) || (size > (64'd128 << LINES_W));
    nl = exp_err ? 0 : int'((size + 64'd127) / 64'd128);
    cmd_q.delete(); pend_q.delete(); out_q.delete();
    done_cnt = 0; done_err = 0; nrsp = 0; err_sent = 0; stall_done = 0;
    cmd_at_err = 0; out_at_err = 0;
    cyc = 0;
    while (!read_ready && cyc < 50) begin tick(); cyc++; end
    chk("ready_before_req", read_ready, 1);
    read_addr = addr; read_size = size; read_req = 1;
    tick();
    read_req = 0;
    lat = 1; cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      cmd_ready = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      out_ready = (cyc < stall) ? 1'b0 : ($urandom_range(0, 99) < p_out);
      if (stall > 0 && cyc >= stall && !stall_done) begin
        stall_done = 1;
        chk("stall_cmd_count", cmd_q.size(), NTAGS);
        chk("stall_cmd_valid", cmd_valid, 0);
      end
      if (pend_q.size() > 0 && (mode != 2 || nrsp > 0 || pend_q.size() >= ((nl < 3) ? nl : 3))) begin
        pi = (mode == 0) ? $urandom_range(0, pend_q.size() - 1) :
             (mode == 2 && nrsp == 0) ? pend_q.size() - 1 : 0;
        respond(pi, addr, err_line, failed);
        nrsp++; cyc += 2; lat += 2;
        if (failed) begin
          err_sent = 1; cmd_at_err = cmd_q.size(); out_at_err = out_q.size();
        end
      end else begin
        tick(); cyc++; lat++;
      end
    end
    out_ready = 0; cmd_ready = 0;
    if (exp_err || nl == 0) chk("done_latency", lat, 2);
    tick();
    chk("ready_after_done", read_ready, 1);
    chk("done_pulses", done_cnt, 1);
    chk("done_error", done_err, exp_err || err_sent);
    if (err_sent) begin
      chk("no_cmd_after_err", cmd_q.size(), cmd_at_err);
      chk("no_out_after_err", out_q.size(), out_at_err);
      chk("out_before_err_line", out_q.size() <= err_line, 1);
    end else begin
      chk("cmd_count", cmd_q.size(), nl);
      chk("out_count", out_q.size(), nl);
    end
    foreach (cmd_q[k]) begin
      chk("cmd_tag", cmd_q[k].tag, k % NTAGS);
      chk("cmd_ea", cmd_q[k].ea, addr + 64'(128 * k));
    end
    foreach (out_q[k]) begin
      chk("out_data", out_q[k].data === line_data[k], 1);
      chk("out_bytes", out_q[k].bytes, (k == nl - 1 && size[6:0] != 0) ? size[6:0] : 128);
      chk("out_last", out_q[k].last, k == nl - 1);
    end
  endtask

  initial begin
    int cyc, nl_r, err_r;
    logic [63:0] a_r, s_r;
    reset = 1; read_req = 0; read_addr = 0; read_size = 0;
    cmd_ready = 0; bw_valid = 0; bw_tag = 0; bw_ad = 0; bw_data = 0;
    rsp_valid = 0; rsp_tag = 0; rsp_code = 0; out_ready = 0;
    done_cnt = 0; done_err = 0;
    tick(); tick();
    chk("rst_read_ready", read_ready, 1);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_rd_done", rd_done, 0);
    chk("rst_rd_error", rd_error, 0);
    reset = 0;
    tick();

    run_job(64'h1000, 512, 1, -1, 0, 100);
    chk("cmd_size", cmd_size, 128);
    run_job(64'h8000, 300, 2, -1, 0, 100);
    run_job(64'h10000, 1280, 0, -1, 60, 70);
    run_job(64'h2000, 1280, 1, 1, 0, 100);
    run_job(64'h1004, 512, 0, -1, 0, 100);
    run_job(64'h3000, 0, 0, -1, 0, 100);
    run_job(64'h3000, (64'd128 << LINES_W) + 1, 0, -1, 0, 100);

    cmd_q.delete(); pend_q.delete(); out_q.delete();
    read_addr = 64'h4000; read_size = 1280; read_req = 1;
    tick();
    read_req = 0; cmd_ready = 1; out_ready = 0; cyc = 0;
    while (cmd_q.size() < 3 && cyc < 50) begin tick(); cyc++; end
    cmd_ready = 0;
    tick();
    chk("pre_reset_outstanding", cmd_q.size(), 3);
    reset = 1;
    tick();
    reset = 0;
    chk("midjob_rst_ready", read_ready, 1);
    chk("midjob_rst_cmd_valid", cmd_valid, 0);
    chk("midjob_rst_out_valid", out_valid, 0);
    run_job(64'h4000, 384, 1, -1, 0, 100);

    for (int j = 0; j < 6; j++) begin
      a_r = 64'h100000 + (64'($urandom_range(0, 255)) << 7);
      s_r = 64'($urandom_range(1, 40 * 128));
      nl_r = int'((s_r + 64'd127) / 64'd128);
      err_r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nl_r - 1) : -1;
      run_job(a_r, s_r, 0, err_r, 0, 60);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
